// File: rtl/xpt_pkg.sv
// Shared types and widths for the execution phase sequencer.
package xpt_pkg;

    localparam int unsigned XptWidth    = 4;
    localparam int unsigned ItableWidth = 8;

    typedef enum logic [1:0] {
        StRun,
        StStretch,
        StFault
    } xpt_state_e;

endpackage

// File: rtl/xpt_sequencer_if.sv
// Handshake bundle between bus/memory timing, the decoders and the phase sequencer.
interface xpt_sequencer_if;

    logic                               enable;
    logic                               reset_xpt;
    logic                               mem_req;
    logic                               mem_wait;
    logic                               load_itable;
    logic [xpt_pkg::ItableWidth-1:0]    itable_in;
    logic                               reset_itable;
    logic                               clear_fault;

    logic [xpt_pkg::XptWidth-1:0]       XPT;
    logic [xpt_pkg::XptWidth-1:0]       notXPT;
    logic [xpt_pkg::ItableWidth-1:0]    ITABLE;
    logic [xpt_pkg::ItableWidth-1:0]    notITABLE;
    logic                               decode_enable;
    logic                               stalled;
    logic                               fault;

    modport master (
        output enable, reset_xpt, mem_req, mem_wait, load_itable, itable_in,
               reset_itable, clear_fault,
        input  XPT, notXPT, ITABLE, notITABLE, decode_enable, stalled, fault
    );

    modport slave (
        input  enable, reset_xpt, mem_req, mem_wait, load_itable, itable_in,
               reset_itable, clear_fault,
        output XPT, notXPT, ITABLE, notITABLE, decode_enable, stalled, fault
    );

endinterface

// File: rtl/xpt_stretch_counter.sv
// 2-bit down-counter with load, saturating at zero; counts remaining minimum stretch cycles.
module xpt_stretch_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       load,
    input  logic       dec,
    input  logic [1:0] load_value,
    output logic [1:0] count,
    output logic       zero
);

    logic [1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 2'd0;
        end else if (enable) begin
            if (load) begin
                count_q <= load_value;
            end else if (dec && (count_q != 2'd0)) begin
                count_q <= count_q - 2'd1;
            end
        end
    end

    assign count = count_q;
    assign zero  = (count_q == 2'd0);

endmodule

// File: rtl/xpt_sequencer.sv
// Execution phase sequencer: owns XPT and ITABLE plus their complements for the decoder tree.
module xpt_sequencer
    import xpt_pkg::*;
#(
    parameter int unsigned XPT_MAX  = 15,
    parameter int unsigned WAIT_MIN = 0
) (
    input logic            clk,
    input logic            reset,
    xpt_sequencer_if.slave bus
);

    localparam logic [XptWidth-1:0] XptMaxVal  = XptWidth'(XPT_MAX);
    localparam logic [1:0]          WaitMinVal = 2'(WAIT_MIN);

    xpt_state_e             state_q;
    logic [XptWidth-1:0]    xpt_q, not_xpt_q, xpt_inc;
    logic [ItableWidth-1:0] itable_q, not_itable_q;
    logic                   decode_enable_q, stalled_q, fault_q;

    logic [1:0] cnt;
    logic       cnt_zero, cnt_load, cnt_dec;
    logic       at_max, stretch_done;

    always_comb begin
        xpt_inc  = xpt_q + XptWidth'(1);
        at_max   = (xpt_q == XptMaxVal);
        // A memory cycle with no minimum and no wait is finished already: just advance.
        cnt_load = (state_q == StRun) && !bus.reset_xpt && bus.mem_req &&
                   ((WaitMinVal != 2'd0) || bus.mem_wait);
        cnt_dec  = (state_q == StStretch);
        // Counter holds the stretch cycles still owed including the current one.
        stretch_done = (cnt_zero || (cnt == 2'd1)) && !bus.mem_wait;
    end

    xpt_stretch_counter u_stretch_counter (
        .clk        (clk),
        .reset      (reset),
        .enable     (bus.enable),
        .load       (cnt_load),
        .dec        (cnt_dec),
        .load_value (WaitMinVal),
        .count      (cnt),
        .zero       (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StRun;
            xpt_q           <= '0;
            not_xpt_q       <= '1;
            itable_q        <= '0;
            not_itable_q    <= '1;
            decode_enable_q <= 1'b1;
            stalled_q       <= 1'b0;
            fault_q         <= 1'b0;
        end else if (bus.enable) begin
            if (bus.load_itable) begin
                itable_q     <= bus.itable_in;
                not_itable_q <= ~bus.itable_in;
            end else if (bus.reset_itable) begin
                itable_q     <= '0;
                not_itable_q <= '1;
            end

            unique case (state_q)
                StRun: begin
                    if (bus.reset_xpt) begin
                        xpt_q     <= '0;
                        not_xpt_q <= '1;
                    end else if (cnt_load) begin
                        state_q         <= StStretch;
                        decode_enable_q <= 1'b0;
                        stalled_q       <= 1'b1;
                    end else if (at_max) begin
                        state_q         <= StFault;
                        decode_enable_q <= 1'b0;
                        fault_q         <= 1'b1;
                    end else begin
                        xpt_q     <= xpt_inc;
                        not_xpt_q <= ~xpt_inc;
                    end
                end
                StStretch: begin
                    if (stretch_done) begin
                        stalled_q <= 1'b0;
                        if (at_max) begin
                            state_q <= StFault;
                            fault_q <= 1'b1;
                        end else begin
                            state_q         <= StRun;
                            decode_enable_q <= 1'b1;
                            xpt_q           <= xpt_inc;
                            not_xpt_q       <= ~xpt_inc;
                        end
                    end
                end
                StFault: begin
                    if (bus.clear_fault) begin
                        state_q         <= StRun;
                        decode_enable_q <= 1'b1;
                        fault_q         <= 1'b0;
                        xpt_q           <= '0;
                        not_xpt_q       <= '1;
                    end
                end
                default: begin
                    state_q         <= StRun;
                    decode_enable_q <= 1'b1;
                    stalled_q       <= 1'b0;
                    fault_q         <= 1'b0;
                end
            endcase
        end
    end

    assign bus.XPT           = xpt_q;
    assign bus.notXPT        = not_xpt_q;
    assign bus.ITABLE        = itable_q;
    assign bus.notITABLE     = not_itable_q;
    assign bus.decode_enable = decode_enable_q;
    assign bus.stalled       = stalled_q;
    assign bus.fault         = fault_q;

endmodule

// File: tb/tb_xpt_sequencer.sv
// Randomized and directed bench for xpt_sequencer against a behavioural phase model.
module tb_xpt_sequencer;

    localparam int unsigned XptMax  = 15;
    localparam int unsigned WaitMin = 2;

    logic clk = 1'b0;
    logic reset;

    xpt_sequencer_if bus ();

    xpt_sequencer #(
        .XPT_MAX  (XptMax),
        .WAIT_MIN (WaitMin)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: phase number, table byte, whether a memory cycle is being stretched
    // (and how many stretch cycles have elapsed), whether the sequencer is faulted.
    int m_xpt     = 0;
    int m_itable  = 0;
    bit m_stretch = 1'b0;
    int m_elapsed = 0;
    bit m_fault   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_advance();
        if (m_xpt == int'(XptMax)) m_fault = 1'b1;
        else m_xpt = m_xpt + 1;
    endtask

    task automatic model_step();
        if (reset) begin
            m_xpt = 0; m_itable = 0; m_stretch = 1'b0; m_elapsed = 0; m_fault = 1'b0;
        end else if (bus.enable) begin
            if (bus.load_itable) m_itable = int'(bus.itable_in);
            else if (bus.reset_itable) m_itable = 0;
            if (m_fault) begin
                if (bus.clear_fault) begin
                    m_fault = 1'b0;
                    m_xpt   = 0;
                end
            end else if (m_stretch) begin
                // Stalled cycles total max(WaitMin, cycles mem_wait stays high).
                if ((m_elapsed + 1 >= int'(WaitMin)) && !bus.mem_wait) begin
                    m_stretch = 1'b0;
                    model_advance();
                end else begin
                    m_elapsed = m_elapsed + 1;
                end
            end else if (bus.reset_xpt) begin
                m_xpt = 0;
            end else if (bus.mem_req && (WaitMin > 0 || bus.mem_wait)) begin
                m_stretch = 1'b1;
                m_elapsed = 0;
            end else begin
                model_advance();
            end
        end
    endtask

    task automatic compare_all();
        logic [3:0] ex;
        logic [7:0] ei;
        ex = 4'(m_xpt);
        ei = 8'(m_itable);
        check_eq("xpt_pair", 32'({bus.XPT, bus.notXPT}), 32'({ex, ~ex}));
        check_eq("itable_pair", 32'({bus.ITABLE, bus.notITABLE}), 32'({ei, ~ei}));
        check_eq("ctl", 32'({bus.decode_enable, bus.stalled, bus.fault}),
                 32'({!m_fault && !m_stretch, m_stretch, m_fault}));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle();
        reset            = 1'b0;
        bus.enable       = 1'b1;
        bus.reset_xpt    = 1'b0;
        bus.mem_req      = 1'b0;
        bus.mem_wait     = 1'b0;
        bus.load_itable  = 1'b0;
        bus.itable_in    = 8'h00;
        bus.reset_itable = 1'b0;
        bus.clear_fault  = 1'b0;
    endtask

    task automatic run_to(input int k);
        bus.reset_xpt = 1'b1;
        cyc();
        bus.reset_xpt = 1'b0;
        repeat (k) cyc();
    endtask

    // Memory cycle at phase 5; mem_wait high in the request cycle if w0 and for extra more.
    task automatic stretch_at5(input bit w0, input int extra, input int exp_hold);
        int hold;
        int stalls;
        run_to(5);
        bus.mem_req  = 1'b1;
        bus.mem_wait = w0;
        cyc();
        bus.mem_req = 1'b0;
        hold   = 0;
        stalls = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.XPT != 4'd5) break;
            hold++;
            if (bus.stalled) stalls++;
            bus.mem_wait = (i < extra);
            cyc();
        end
        bus.mem_wait = 1'b0;
        check_eq("stretch_hold", 32'(hold), 32'(exp_hold));
        check_eq("stretch_stalls", 32'(stalls), 32'(exp_hold));
        check_eq("stretch_next", 32'(bus.XPT), 32'd6);
    endtask

    initial begin
        idle();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check_eq("reset_ctl", 32'({bus.decode_enable, bus.stalled, bus.fault}), 32'b100);

        repeat (15) cyc();
        check_eq("xpt_at_max", 32'(bus.XPT), 32'd15);
        cyc();
        check_eq("fault_at_max", 32'({bus.fault, bus.XPT}), 32'h1F);
        bus.clear_fault = 1'b1;
        cyc();
        bus.clear_fault = 1'b0;
        check_eq("clear_fault_xpt", 32'(bus.XPT), 32'd0);

        run_to(7);
        bus.reset_xpt = 1'b1;
        cyc();
        bus.reset_xpt = 1'b0;
        check_eq("restart_pair", 32'({bus.XPT, bus.notXPT}), 32'h0F);
        run_to(7);
        bus.reset_xpt = 1'b1;
        bus.mem_req   = 1'b1;
        cyc();
        idle();
        check_eq("restart_no_stall", 32'({bus.XPT, bus.stalled}), 32'h0);

        stretch_at5(1'b0, 0, 2);
        stretch_at5(1'b1, 3, 4);

        bus.load_itable = 1'b1;
        bus.itable_in   = 8'hFE;
        cyc();
        check_eq("itable_load", 32'({bus.ITABLE, bus.notITABLE}), 32'hFE01);
        bus.load_itable  = 1'b0;
        bus.reset_itable = 1'b1;
        cyc();
        check_eq("itable_clear", 32'({bus.ITABLE, bus.notITABLE}), 32'h00FF);
        bus.load_itable = 1'b1;
        bus.itable_in   = 8'h36;
        cyc();
        idle();
        check_eq("itable_load_wins", 32'({bus.ITABLE, bus.notITABLE}), 32'h36C9);

        // Freeze mid-stretch, then let it resume.
        run_to(3);
        bus.mem_req  = 1'b1;
        bus.mem_wait = 1'b1;
        cyc();
        bus.mem_req = 1'b0;
        bus.enable  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.mem_wait = ((i % 2) == 0);
            cyc();
        end
        check_eq("frozen_xpt", 32'({bus.XPT, bus.stalled}), 32'h7);
        bus.enable   = 1'b1;
        bus.mem_wait = 1'b0;
        repeat (4) cyc();

        run_to(4);
        bus.mem_req = 1'b1;
        cyc();
        bus.mem_req = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check_eq("reset_in_stretch",
                 32'({bus.decode_enable, bus.stalled, bus.fault, bus.XPT, bus.notXPT}), 32'h40F);

        run_to(15);
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check_eq("reset_in_fault",
                 32'({bus.decode_enable, bus.stalled, bus.fault, bus.ITABLE, bus.notITABLE}),
                 32'h400FF);

        for (int i = 0; i < 3000; i++) begin
            reset            = ($urandom_range(99) < 2);
            bus.enable       = ($urandom_range(99) < 85);
            bus.reset_xpt    = ($urandom_range(99) < 8);
            bus.mem_req      = ($urandom_range(99) < 20);
            bus.mem_wait     = ($urandom_range(99) < 35);
            bus.load_itable  = ($urandom_range(99) < 12);
            bus.reset_itable = ($urandom_range(99) < 12);
            bus.clear_fault  = ($urandom_range(99) < 30);
            bus.itable_in    = 8'($urandom);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/xpt_sequencer.md
# xpt_sequencer

Phase sequencer for the instruction decoders. It owns the 4-bit execution phase timer `XPT` and the latched decode table byte `ITABLE`, and drives both with their complements into the `DECODER_*` tree. It advances one phase per clock, stretches a phase while a memory cycle is waiting, and restarts on the decoders' reset-phase request. It sits between the bus/memory timing logic and the opcode decoders. It is the only writer of `XPT` and `ITABLE`.

## Interface
- `XPT_MAX`, default 15: highest legal phase; advancing past it is a fault.
- `WAIT_MIN`, default 0: minimum number of stretch cycles inserted per memory cycle (0..3).
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: advance permission; when low, all state holds and nothing advances.
- `reset_xpt` in 1: phase restart request (OR of all decoder `PR_Reset_XPT` outputs).
- `mem_req` in 1: the current phase starts a memory cycle (OR of `PC_W*` / read strobes).
- `mem_wait` in 1: external wait; the memory cycle is not finished.
- `load_itable` in 1: capture `itable_in` (opcode fetch complete).
- `itable_in` in 8: next table byte.
- `reset_itable` in 1: clear `ITABLE` (OR of `P2_Reset_ITABLE`).
- `clear_fault` in 1: leave FAULT.
- `XPT` / `notXPT` out 4 / 4: phase and its exact bitwise complement.
- `ITABLE` / `notITABLE` out 8 / 8: table byte and its exact bitwise complement.
- `decode_enable` out 1: decoders may act this cycle.
- `stalled` out 1: phase is being stretched.
- `fault` out 1: phase overflow detected (sticky).

## Operation
- State machine with three states: RUN, STRETCH, FAULT.
- Reset values: state RUN, `XPT`=0, `notXPT`=4'hF, `ITABLE`=0, `notITABLE`=8'hFF, `decode_enable`=1, `stalled`=0, `fault`=0, stretch counter 0.
- RUN, update priority (highest first):
  1. `reset_xpt`: `XPT`←0.
  2. `mem_req`: go to STRETCH, with the stretch counter ← `WAIT_MIN` and `XPT` holding. If `WAIT_MIN`=0 and `mem_wait`=0, do not enter STRETCH; advance instead.
  3. `XPT`=`XPT_MAX`: go to FAULT with `XPT` held.
  4. Otherwise `XPT`←`XPT`+1.
- STRETCH:
  - `decode_enable`=0 and `stalled`=1.
  - The counter decrements to 0.
  - Exit when the counter is 0 and `mem_wait`=0. On exit, `XPT` advances (or goes to FAULT at `XPT_MAX`) and the state returns to RUN.
  - `reset_xpt` is ignored in STRETCH, because `decode_enable` is 0 and decoders cannot raise it.
- FAULT:
  - `decode_enable`=0 and `fault`=1.
  - `XPT` is frozen.
  - `clear_fault` → RUN with `XPT`=0.
- ITABLE:
  - Updates in any state whenever `enable`=1.
  - `load_itable` wins over `reset_itable` in the same cycle (the next opcode fetch overlaps the final phase).
- `reset` overrides everything, including while in STRETCH or FAULT.
- `notXPT`/`notITABLE` are registered alongside `XPT`/`ITABLE`, never derived by a separate path. Their complement relation holds every cycle.

## Timing
- `reset_xpt` sampled at edge n → `XPT`=0 visible after edge n.
- Plain advance: one phase per clock.
- Memory cycle at phase k: `XPT`=k is held for max(`WAIT_MIN`, cycles `mem_wait` is high) additional cycles, then becomes k+1.
- `stalled` and `decode_enable` are registered from the state, so they change in the same cycle as the state.
- `enable`=0 freezes the state, counter and both registers. Inputs sampled while `enable`=0 are dropped, except `reset`.
- Simultaneous `reset_xpt` and `mem_req` in RUN: the restart wins and no stretch is entered.

## Structure
- Shared package `xpt_pkg` holds:
  - the state enumeration (RUN, STRETCH, FAULT);
  - the `XPT` width constant 4 and the `ITABLE` width constant 8.
- One natural sub-module, `xpt_stretch_counter`: a 2-bit down-counter with load and zero flag.
- Everything else stays flat.

## Test plan
- Reset then 16 free-running cycles with no requests: `XPT` steps 0..15; the next cycle gives `fault`=1 with `XPT` held at 15. `clear_fault` then gives `XPT`=0 next cycle.
- `reset_xpt` pulse at `XPT`=7 → `XPT`=0 next cycle, `notXPT`=4'hF. Repeat with `mem_req` in the same cycle: no `stalled`.
- `WAIT_MIN`=2, `mem_req` at `XPT`=5, `mem_wait`=0: `XPT`=5 for 3 cycles total with `stalled` high 2 cycles, then 6. With `mem_wait` high 4 cycles: `XPT`=5 for 5 cycles.
- `load_itable` with `itable_in`=8'hFE, then `reset_itable` alone → `ITABLE`=8'hFE / `notITABLE`=8'h01, then 0 / 8'hFF. Both asserted together with 8'h36 → `ITABLE`=8'h36.
- `enable` low for 3 cycles mid-STRETCH with `mem_wait` toggling: counter and `XPT` frozen; the sequence resumes identically afterwards.
- `reset` asserted in STRETCH and in FAULT → all outputs at reset values next cycle.
